// File: rtl/fir_mon_pkg.sv
// Shared types and sizing helpers for the FIR peak monitor.
package fir_mon_pkg;

  typedef enum logic [1:0] {StIdle, StSettle, StMeasure, StDone} state_t;

  // Widest channel sample that sat_abs can handle.
  localparam int unsigned MaxDataW = 256;

  function automatic int unsigned idx_w(input int unsigned win_len);
    return (win_len > 2) ? $clog2(win_len) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned settle_len,
                                        input int unsigned win_len);
    int unsigned m;
    m = (settle_len > win_len) ? settle_len : win_len;
    return $clog2(m + 1);
  endfunction

  // x is a data_w-bit value sign-extended to MaxDataW; the most negative code saturates.
  function automatic logic [MaxDataW-1:0] sat_abs(input logic [MaxDataW-1:0] x,
                                                  input int unsigned data_w);
    logic [MaxDataW-1:0] min_neg;
    min_neg = {MaxDataW{1'b1}} << (data_w - 1);
    if (x == min_neg) return ~min_neg;
    if (x[MaxDataW-1]) return -x;
    return x;
  endfunction

endpackage

// File: rtl/fir_peak_monitor_ch.sv
// Per-channel running peak tracker; outputs already include the sample accepted this cycle.
module peak_track_ch
  import fir_mon_pkg::*;
#(
  parameter int unsigned DATA_W   = 40,
  parameter int unsigned IDX_W    = 1,
  parameter bit          ABS_MODE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              upd,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] peak,
  output logic [IDX_W-1:0]  peak_idx
);

  logic [MaxDataW-1:0] mag_full;
  logic                unused_mag_hi;
  logic [DATA_W-1:0]   val;
  logic [DATA_W-1:0]   peak_q, peak_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                take;

  assign mag_full      = sat_abs({{(MaxDataW - DATA_W){sample[DATA_W-1]}}, sample}, DATA_W);
  assign unused_mag_hi = ^mag_full[MaxDataW-1:DATA_W];
  assign val           = ABS_MODE ? mag_full[DATA_W-1:0] : sample;

  // Strictly-greater keeps the earliest index on ties.
  assign take = upd & (load | ($signed(val) > $signed(peak_q)));

  always_comb begin
    peak_d = take ? val : peak_q;
    idx_d  = take ? idx : idx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q <= '0;
      idx_q  <= '0;
    end else begin
      peak_q <= peak_d;
      idx_q  <= idx_d;
    end
  end

  assign peak     = peak_d;
  assign peak_idx = idx_d;

endmodule

// File: rtl/fir_peak_monitor.sv
// Discards a settling interval of valid samples, then reports per-channel peak and its index.
module fir_peak_monitor
  import fir_mon_pkg::*;
#(
  parameter int unsigned DATA_W     = 40,
  parameter int unsigned NUM_CH     = 1,
  parameter int unsigned SETTLE_LEN = 340,
  parameter int unsigned WIN_LEN    = 2000,
  parameter int unsigned ABS_MODE   = 0,
  localparam int unsigned IDX_W     = idx_w(WIN_LEN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_CH*DATA_W-1:0] peak_data,
  output logic [NUM_CH*IDX_W-1:0]  peak_idx
);

  localparam int unsigned CNT_W = cnt_w(SETTLE_LEN, WIN_LEN);
  localparam logic [CNT_W-1:0] SettleLast = CNT_W'((SETTLE_LEN > 0) ? SETTLE_LEN - 1 : 0);
  localparam logic [CNT_W-1:0] WinLast    = CNT_W'(WIN_LEN - 1);

  state_t                   state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     win_upd;
  logic                     win_first;
  logic [NUM_CH*DATA_W-1:0] run_peak;
  logic [NUM_CH*IDX_W-1:0]  run_idx;

  assign win_upd   = (state_q == StMeasure) & in_valid;
  assign win_first = (cnt_q == '0);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    peak_track_ch #(
      .DATA_W  (DATA_W),
      .IDX_W   (IDX_W),
      .ABS_MODE(ABS_MODE != 0)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .load    (win_first),
      .upd     (win_upd),
      .idx     (cnt_q[IDX_W-1:0]),
      .sample  (in_data[c*DATA_W +: DATA_W]),
      .peak    (run_peak[c*DATA_W +: DATA_W]),
      .peak_idx(run_idx[c*IDX_W +: IDX_W])
    );
  end

  // Results are captured on entry to StDone so they are visible while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      peak_data <= '0;
      peak_idx  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= (SETTLE_LEN == 0) ? StMeasure : StSettle;
          end
        end
        StSettle: begin
          if (in_valid) begin
            if (cnt_q == SettleLast) begin
              cnt_q   <= '0;
              state_q <= StMeasure;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        StMeasure: begin
          if (in_valid) begin
            if (cnt_q == WinLast) begin
              cnt_q     <= '0;
              done      <= 1'b1;
              peak_data <= run_peak;
              peak_idx  <= run_idx;
              state_q   <= StDone;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_peak_monitor.sv
// Directed and randomized checks of fir_peak_monitor in three configurations.
module tb_fir_peak_monitor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // A: basic signed, B: abs mode, C: two channels
  logic        start_a, valid_a, busy_a, done_a;
  logic [15:0] data_a, peak_a;
  logic [2:0]  idx_a;
  logic        start_b, valid_b, busy_b, done_b;
  logic [7:0]  data_b, peak_b;
  logic [1:0]  idx_b;
  logic        start_c, valid_c, busy_c, done_c;
  logic [23:0] data_c, peak_c;
  logic [3:0]  idx_c;

  fir_peak_monitor #(.DATA_W(16), .NUM_CH(1), .SETTLE_LEN(3), .WIN_LEN(5), .ABS_MODE(0)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(valid_a), .in_data(data_a),
    .busy(busy_a), .done(done_a), .peak_data(peak_a), .peak_idx(idx_a)
  );
  fir_peak_monitor #(.DATA_W(8), .NUM_CH(1), .SETTLE_LEN(0), .WIN_LEN(4), .ABS_MODE(1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(valid_b), .in_data(data_b),
    .busy(busy_b), .done(done_b), .peak_data(peak_b), .peak_idx(idx_b)
  );
  fir_peak_monitor #(.DATA_W(12), .NUM_CH(2), .SETTLE_LEN(0), .WIN_LEN(3), .ABS_MODE(0)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .in_valid(valid_c), .in_data(data_c),
    .busy(busy_c), .done(done_c), .peak_data(peak_c), .peak_idx(idx_c)
  );

  int    p_dw[3]  = '{16, 8, 12};
  int    p_s[3]   = '{3, 0, 0};
  int    p_w[3]   = '{5, 4, 3};
  int    p_abs[3] = '{0, 1, 0};
  int    p_nch[3] = '{1, 1, 2};
  string p_nm[3]  = '{"A", "B", "C"};

  int sv[2][16];       // stimulus per channel: settle samples then window samples
  int prev_pk[3][2];   // result each instance should currently be reporting
  int prev_ix[3][2];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: peak of window values (magnitude with saturation in abs mode), earliest index wins.
  task automatic model(input int sel);
    int best, bi, v, half;
    half = 1 << (p_dw[sel] - 1);
    for (int c = 0; c < p_nch[sel]; c++) begin
      best = 0;
      bi = 0;
      for (int k = 0; k < p_w[sel]; k++) begin
        v = sv[c][p_s[sel] + k];
        if (p_abs[sel] != 0 && v < 0) v = (v == -half) ? half - 1 : -v;
        if (k == 0 || v > best) begin
          best = v;
          bi = k;
        end
      end
      prev_pk[sel][c] = best;
      prev_ix[sel][c] = bi;
    end
  endtask

  function automatic int rnd(input int dw);
    if ($urandom_range(0, 2) == 0) return int'($urandom_range(0, 6)) - 3;
    return int'($urandom_range(0, (1 << dw) - 1)) - (1 << (dw - 1));
  endfunction

  task automatic fill_rand(input int sel);
    for (int i = 0; i < p_s[sel] + p_w[sel]; i++)
      for (int c = 0; c < 2; c++) sv[c][i] = rnd(p_dw[sel]);
  endtask

  // i < 0 drives random junk data.
  task automatic drive(input int sel, input bit st, input bit vld, input int i);
    int d0, d1;
    if (i >= 0) begin
      d0 = sv[0][i];
      d1 = sv[1][i];
    end else begin
      d0 = int'($urandom);
      d1 = int'($urandom);
    end
    case (sel)
      0: begin start_a = st; valid_a = vld; data_a = 16'(d0); end
      1: begin start_b = st; valid_b = vld; data_b = 8'(d0); end
      default: begin start_c = st; valid_c = vld; data_c = {12'(d1), 12'(d0)}; end
    endcase
  endtask

  task automatic chk_state(input int sel, input bit eb, input bit ed, input string what);
    logic ob, od;
    logic signed [31:0] pk[2];
    logic signed [31:0] ix[2];
    pk[1] = 0;
    ix[1] = 0;
    case (sel)
      0: begin
        ob = busy_a; od = done_a;
        pk[0] = 32'($signed(peak_a)); ix[0] = {29'd0, idx_a};
      end
      1: begin
        ob = busy_b; od = done_b;
        pk[0] = 32'($signed(peak_b)); ix[0] = {30'd0, idx_b};
      end
      default: begin
        ob = busy_c; od = done_c;
        pk[0] = 32'($signed(peak_c[11:0])); pk[1] = 32'($signed(peak_c[23:12]));
        ix[0] = {30'd0, idx_c[1:0]}; ix[1] = {30'd0, idx_c[3:2]};
      end
    endcase
    chk($sformatf("%s/%s/busy", p_nm[sel], what), {31'd0, ob}, {31'd0, eb});
    chk($sformatf("%s/%s/done", p_nm[sel], what), {31'd0, od}, {31'd0, ed});
    for (int c = 0; c < p_nch[sel]; c++) begin
      chk($sformatf("%s/%s/peak%0d", p_nm[sel], what, c), pk[c], prev_pk[sel][c]);
      chk($sformatf("%s/%s/idx%0d", p_nm[sel], what, c), ix[c], prev_ix[sel][c]);
    end
  endtask

  // One full measurement on instance sel using sv; checks every cycle.
  task automatic run(input int sel, input int gap, input bit poke, input bit b2b);
    int n_tot;
    n_tot = p_s[sel] + p_w[sel];
    if (!b2b) begin
      drive(sel, 1'b0, 1'b1, -1);
      step();
      chk_state(sel, 1'b0, 1'b0, "idle-junk");
    end
    drive(sel, 1'b1, 1'b0, -1);
    step();
    chk_state(sel, 1'b1, 1'b0, "started");
    for (int i = 0; i < n_tot; i++) begin
      drive(sel, poke && (i == p_s[sel]), 1'b1, i);
      step();
      if (i == n_tot - 1) begin
        model(sel);
        chk_state(sel, 1'b1, 1'b1, "done");
      end else begin
        chk_state(sel, 1'b1, 1'b0, "run");
        for (int g = 0; g < gap; g++) begin
          drive(sel, 1'b0, 1'b0, -1);
          step();
          chk_state(sel, 1'b1, 1'b0, "gap");
        end
      end
    end
    drive(sel, poke, 1'b1, -1);
    step();
    chk_state(sel, 1'b0, 1'b0, "after");
    drive(sel, 1'b0, 1'b0, -1);
    if (poke) begin
      step();
      chk_state(sel, 1'b0, 1'b0, "ignored");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      drive(s, 1'b0, 1'b0, -1);
      prev_pk[s] = '{0, 0};
      prev_ix[s] = '{0, 0};
    end
    step();
    step();
    for (int s = 0; s < 3; s++) chk_state(s, 1'b0, 1'b0, "reset");
    rst = 1'b0;
    step();

    // Basic: settle 9,9,9 then window 4,-2,17,17,3
    sv[0][0] = 9;  sv[0][1] = 9;  sv[0][2] = 9;  sv[0][3] = 4;
    sv[0][4] = -2; sv[0][5] = 17; sv[0][6] = 17; sv[0][7] = 3;
    run(0, 0, 1'b0, 1'b0);
    // Same data with gaps, start poked in MEASURE and on the done cycle
    run(0, 2, 1'b1, 1'b0);
    // Back-to-back with a different peak
    sv[0][0] = 1;  sv[0][1] = 2;  sv[0][2] = 3;   sv[0][3] = -7;
    sv[0][4] = 50; sv[0][5] = 12; sv[0][6] = 50;  sv[0][7] = -100;
    run(0, 0, 1'b0, 1'b1);

    // Abs mode: -128 saturates to 127
    sv[0][0] = 5; sv[0][1] = -100; sv[0][2] = -128; sv[0][3] = 90;
    run(1, 1, 1'b0, 1'b0);

    // Two channels
    sv[0][0] = -1; sv[0][1] = -5; sv[0][2] = -3;
    sv[1][0] = 0;  sv[1][1] = 7;  sv[1][2] = 8;
    run(2, 0, 1'b1, 1'b0);

    // Reset in the middle of a window, then a clean measurement
    fill_rand(0);
    drive(0, 1'b1, 1'b0, -1);
    step();
    for (int i = 0; i < p_s[0] + 2; i++) begin
      drive(0, 1'b0, 1'b1, i);
      step();
    end
    rst = 1'b1;
    drive(0, 1'b0, 1'b1, -1);
    step();
    for (int s = 0; s < 3; s++) begin
      prev_pk[s] = '{0, 0};
      prev_ix[s] = '{0, 0};
      chk_state(s, 1'b0, 1'b0, "midrst");
    end
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, -1);
    step();
    chk_state(0, 1'b0, 1'b0, "postrst");
    fill_rand(0);
    run(0, 1, 1'b0, 1'b0);

    for (int r = 0; r < 12; r++) begin
      int sel;
      sel = int'($urandom_range(0, 2));
      fill_rand(sel);
      run(sel, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_peak_monitor.md
Name: fir_peak_monitor

Overview:
- Hardware successor to the bench-side max-tracking loop used for FIR frequency-response sweeps.
- Sits on the filter output:
  - discards a programmable settling interval of valid samples;
  - then tracks the per-channel peak (signed or magnitude) over a programmable window;
  - reports the peak value and the sample index at which it occurred.
- Generalised over data width and channel count, with an absolute-value mode and a start/busy/done handshake.

Parameters:
- DATA_W, 40, width of each channel sample (signed two's complement).
- NUM_CH, 1, number of independent channels sampled in lockstep.
- SETTLE_LEN, 340, valid samples discarded after start (0 allowed = no settle).
- WIN_LEN, 2000, valid samples in the measurement window (>=1).
- ABS_MODE, 0, 0 = signed max; 1 = max of saturated absolute value.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a measurement.
- in_valid  in  1  qualifies in_data; only valid samples are counted.
- in_data  in  NUM_CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W], signed.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when results update.
- peak_data  out  NUM_CH*DATA_W  per-channel peak, same packing as in_data.
- peak_idx  out  NUM_CH*IDX_W  per-channel window index of the peak; IDX_W = max(1,$clog2(WIN_LEN)).

Behaviour:
- Reset: synchronous, active-high. All outputs reset to 0. FSM goes to IDLE and counters clear.
- Reset mid-measurement aborts the measurement. peak_data/peak_idx return to 0.
- FSM states: IDLE, SETTLE, MEASURE, DONE.
- IDLE:
  - start=1 is accepted: go to SETTLE, or to MEASURE if SETTLE_LEN==0.
  - Settle counter clears. busy=1 next cycle.
- SETTLE:
  - Each in_valid increments the settle counter.
  - On the SETTLE_LEN-th valid sample, go to MEASURE. That sample is not measured.
- MEASURE:
  - Each in_valid sample is window index k = 0..WIN_LEN-1.
  - k==0: load each channel's running peak with the sample value and set its index to 0.
  - k>0: replace the running peak only if the value is strictly greater. Ties keep the earliest index.
  - On k==WIN_LEN-1 (processed with the same update rule), go to DONE.
- DONE (one cycle):
  - Copy running peaks/indices to peak_data/peak_idx.
  - done=1, busy drops to 0 on the following cycle. Return to IDLE.
- Output latency: done asserts the cycle after the final window sample is accepted.
- in_valid gaps stall counting indefinitely. There is no timeout.
- start while busy (SETTLE/MEASURE/DONE) is ignored. There is no restart.
- start in the same cycle as DONE is ignored.
- Samples arriving in IDLE or DONE are ignored.
- peak_data/peak_idx hold their value until the next DONE.
- ABS_MODE=1:
  - Compare |x|. The most negative value -2^(DATA_W-1) saturates to 2^(DATA_W-1)-1.
  - Reported peak is the saturated magnitude (non-negative).
- ABS_MODE=0: signed comparison, raw value reported.
- Channels are independent in comparison but share counters and state.

Decomposition:
- Package fir_mon_pkg:
  - state_t enum {IDLE, SETTLE, MEASURE, DONE};
  - function for IDX_W and counter width = $clog2(max(SETTLE_LEN, WIN_LEN)+1);
  - function sat_abs(DATA_W).
- Sub-module peak_track_ch (one per channel, generate loop):
  - inputs: clk, rst, load (k==0), upd (valid in MEASURE), idx, sample;
  - outputs: running peak, running index;
  - holds the ABS_MODE logic.
- Top holds the FSM, counters and output registers.

Test Plan:
- Basic (NUM_CH=1, SETTLE_LEN=3, WIN_LEN=5, ABS_MODE=0): start, then samples 9,9,9 (settle), then 4,-2,17,17,3 -> done 1 cycle after 5th window sample; peak_data=17, peak_idx=2 (tie keeps earliest); busy high for exactly the in-between cycles.
- Gapped valid: same stimulus with in_valid low 2 cycles between each sample -> identical results; done delayed accordingly; ignored samples while in_valid=0 have no effect.
- ABS mode (ABS_MODE=1, DATA_W=8, SETTLE_LEN=0, WIN_LEN=4): samples 5,-100,-128,90 -> peak_data=127 (saturated), peak_idx=2.
- Multi-channel (NUM_CH=2, WIN_LEN=3, SETTLE_LEN=0): ch0 = -1,-5,-3; ch1 = 0,7,8 -> ch0 peak -1 idx0; ch1 peak 8 idx2.
- Control corners:
  - start pulsed during MEASURE and on the DONE cycle -> ignored, single done;
  - rst asserted mid-MEASURE -> outputs 0, busy 0, next start produces a clean full measurement.
- Back-to-back: start on the cycle after done -> second measurement with new data reports new peak; previous result held until second done.
